// File: rtl/cosim_send_arbiter.sv
// cosim_send_arbiter: round-robin share of one cosim endpoint send channel among NUM_CLIENTS requesters.
// Latency: an accepted message is visible on DataIn/DataInValid one cycle after the accepting edge.
// Backpressure: ReqReady stays low while the holding buffer is full and DataInReady is low.
// Optional: define COSIM_SEND_ARB_STATS_EN for per-client AcceptCount counters and grant logging.
module cosim_send_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int MSG_BITS    = 192,
  parameter int MAX_BURST   = 1,
  localparam int CLIENT_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_CLIENTS-1:0]          ReqValid,
  output logic [NUM_CLIENTS-1:0]          ReqReady,
  input  logic [NUM_CLIENTS*MSG_BITS-1:0] ReqData,
  output logic                            DataInValid,
  input  logic                            DataInReady,
  output logic [MSG_BITS-1:0]             DataIn,
  output logic [CLIENT_W-1:0]             DataInClient
`ifdef COSIM_SEND_ARB_STATS_EN
  ,
  output logic [NUM_CLIENTS*32-1:0]       AcceptCount
`endif
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  logic [NUM_CLIENTS-1:0][MSG_BITS-1:0] reqDataArr;
  logic [CLIENT_W-1:0] rrPtr;
  logic [CLIENT_W-1:0] lastGrant;
  logic [7:0]          burstCnt;
  logic [7:0]          newBurst;
  logic [CLIENT_W-1:0] grantIdx;
  logic                grantVld;
  logic                canAccept;
  logic                accept;

  assign reqDataArr = ReqData;

  // Wrap-around successor of a client index.
  function automatic logic [CLIENT_W-1:0] nextIdx(input logic [CLIENT_W-1:0] i);
    if (int'(i) >= NUM_CLIENTS - 1) return '0;
    return i + 1'b1;
  endfunction

  // Buffer can take a new message when empty or draining this cycle.
  assign canAccept = !DataInValid || DataInReady;
  assign accept    = rstn && canAccept && grantVld;

  // Grant selection: continue an unfinished burst, else first valid client from rrPtr.
  always_comb begin : grantSel
    int idx;
    logic [CLIENT_W-1:0] cand;
    grantVld = 1'b0;
    grantIdx = '0;
    idx      = 0;
    cand     = '0;
    if (burstCnt != 8'd0 && burstCnt < MAX_B && ReqValid[lastGrant]) begin
      grantVld = 1'b1;
      grantIdx = lastGrant;
    end else begin
      // Walk offsets from far to near so the nearest valid client wins.
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
        idx = int'(rrPtr) + k;
        if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
        cand = CLIENT_W'(idx);
        if (ReqValid[cand]) begin
          grantVld = 1'b1;
          grantIdx = cand;
        end
      end
    end
  end

  // One-hot ready to the granted client; forced low during reset.
  always_comb begin
    ReqReady = '0;
    if (accept) ReqReady[grantIdx] = 1'b1;
  end

  // Burst length the grant would reach if accepted this cycle.
  always_comb begin
    newBurst = 8'd1;
    if (grantIdx == lastGrant && burstCnt != 8'd0) newBurst = burstCnt + 8'd1;
  end

  // Holding buffer, burst counter and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      DataInValid  <= 1'b0;
      DataIn       <= '0;
      DataInClient <= '0;
      rrPtr        <= '0;
      burstCnt     <= '0;
      lastGrant    <= '0;
    end else if (accept) begin
      DataIn       <= reqDataArr[grantIdx];
      DataInClient <= grantIdx;
      DataInValid  <= 1'b1;
      lastGrant    <= grantIdx;
      if (newBurst >= MAX_B) begin
        rrPtr    <= nextIdx(grantIdx);
        burstCnt <= '0;
      end else begin
        burstCnt <= newBurst;
      end
    end else begin
      if (DataInValid && DataInReady) DataInValid <= 1'b0;
      // A gap from the burst owner ends its burst and passes the turn on.
      if (!ReqValid[lastGrant]) begin
        burstCnt <= '0;
        rrPtr    <= nextIdx(lastGrant);
      end
    end
  end

`ifdef COSIM_SEND_ARB_STATS_EN
  logic [NUM_CLIENTS-1:0][31:0] acceptCnt;
  assign AcceptCount = acceptCnt;

  // Free-running per-client accept counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acceptCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (accept && int'(grantIdx) == i) acceptCnt[i] <= acceptCnt[i] + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  // Grant log for cosim debugging.
  always_ff @(posedge clk) begin
    if (accept) $display("[%0t] arb grant client=%0d", $time, grantIdx);
  end
`endif
`endif

endmodule
